ex_muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide unit for the RV32M extension. It sits in the EX stage beside the single-cycle ALU. It accepts one operation per start pulse and stalls the pipeline while it iterates. It returns the result with its destination-register tag for the EX/MEM register. This is the successor to the single-cycle ALU path: it is generalised to any XLEN and adds a start/busy/done handshake, flush, and multi-cycle sequencing.

---
 rtl/ex_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M-style multiply/divide unit for the EX stage.
// Shift-add multiply (LSB first) and restoring divide (MSB first), XLEN iterations, one fix-up cycle.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [2:0]       funct3_i,
    input  logic [XLEN-1:0]  rs1_i,
    input  logic [XLEN-1:0]  rs2_i,
    input  logic [TAG_W-1:0] rd_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [XLEN-1:0]  result_o,
    output logic [TAG_W-1:0] rd_o
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    state_t             r_state;
    logic [2:0]         r_funct3;
    logic [TAG_W-1:0]   r_rd;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic               r_sign_q;
    logic               r_sign_r;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*XLEN-1:0]  r_prod;
    logic [XLEN-1:0]    r_quo;
    logic [XLEN-1:0]    r_rem;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_rd_out;

    logic               w_idle_or_done;
    logic               w_is_div;
    logic               w_signed_a;
    logic               w_signed_b;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [XLEN-1:0]    w_mag_a;
    logic [XLEN-1:0]    w_mag_b;
    logic               w_div_zero;
    logic               w_div_ovf;
    logic [XLEN-1:0]    w_special_res;
    logic [XLEN:0]      w_mul_sum;
    logic [XLEN:0]      w_trial;
    logic [XLEN:0]      w_diff;
    logic               w_q_bit;
    logic [2*XLEN-1:0]  w_prod_fix;
    logic [XLEN-1:0]    w_quo_fix;
    logic [XLEN-1:0]    w_rem_fix;
    logic [XLEN-1:0]    w_fix_res;

    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign busy_o   = (r_state == S_CALC) || (r_state == S_FIX);
    assign done_o   = (r_state == S_DONE);
    assign stall_o  = busy_o | (start_i & ~flush_i & w_idle_or_done);
    assign result_o = r_result;
    assign rd_o     = r_rd_out;

    // Operand signedness: MULH/DIV/REM both signed, MULHSU only A signed.
    assign w_is_div   = funct3_i[2];
    assign w_signed_a = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                        (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign w_signed_b = (funct3_i == 3'b001) || (funct3_i == 3'b100) || (funct3_i == 3'b110);
    assign w_neg_a    = w_signed_a & rs1_i[XLEN-1];
    assign w_neg_b    = w_signed_b & rs2_i[XLEN-1];
    assign w_mag_a    = w_neg_a ? -rs1_i : rs1_i;
    assign w_mag_b    = w_neg_b ? -rs2_i : rs2_i;

    assign w_div_zero    = w_is_div & (rs2_i == '0);
    assign w_div_ovf     = w_is_div & ~funct3_i[0] & (rs1_i == MIN_NEG) & (rs2_i == ALL_ONES);
    assign w_special_res = w_div_zero ? (funct3_i[1] ? rs1_i : ALL_ONES)
                                      : (funct3_i[1] ? '0 : MIN_NEG);

    assign w_mul_sum = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_a} : '0);

    // Trial subtraction never needs more than XLEN+1 bits since the partial remainder stays below the divisor.
    assign w_trial = {r_rem, r_quo[XLEN-1]};
    assign w_diff  = w_trial - {1'b0, r_b};
    assign w_q_bit = ~w_diff[XLEN];

    assign w_prod_fix = r_sign_q ? -r_prod : r_prod;
    assign w_quo_fix  = r_sign_q ? -r_quo : r_quo;
    assign w_rem_fix  = r_sign_r ? -r_rem : r_rem;
    assign w_fix_res  = r_funct3[2] ? (r_funct3[1] ? w_rem_fix : w_quo_fix)
                                    : ((r_funct3[1:0] == 2'b00) ? w_prod_fix[XLEN-1:0]
                                                                : w_prod_fix[2*XLEN-1:XLEN]);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_cnt    <= '0;
            r_prod   <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_result <= '0;
            r_rd_out <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_funct3 <= funct3_i;
                        r_rd     <= rd_i;
                        r_a      <= w_mag_a;
                        r_b      <= w_mag_b;
                        r_sign_q <= w_neg_a ^ w_neg_b;
                        r_sign_r <= w_neg_a;
                        r_cnt    <= '0;
                        r_prod   <= {{XLEN{1'b0}}, w_mag_b};
                        r_quo    <= w_mag_a;
                        r_rem    <= '0;
                        if (w_div_zero || w_div_ovf) begin
                            r_result <= w_special_res;
                            r_rd_out <= rd_i;
                            r_state  <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    if (r_funct3[2]) begin
                        r_rem <= w_q_bit ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];
                        r_quo <= {r_quo[XLEN-2:0], w_q_bit};
                    end else begin
                        r_prod <= {w_mul_sum, r_prod[XLEN-1:1]};
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(XLEN-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_result <= w_fix_res;
                    r_rd_out <= r_rd;
                    r_state  <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected result/tag/done-cycle queued at issue, checked on done_o.
module tb_ex_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [4:0]  rd_i;
    logic        flush_i;
    logic        busy_o;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    logic        start16;
    logic [2:0]  f3_16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic [4:0]  rd16;
    logic        flush16;
    logic        busy16;
    logic        stall16;
    logic        done16;
    logic [15:0] res16;
    logic [4:0]  rd16_o;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ex_muldiv_unit #(.XLEN(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .funct3_i(funct3_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .flush_i(flush_i),
        .busy_o(busy_o), .stall_o(stall_o), .done_o(done_o),
        .result_o(result_o), .rd_o(rd_o)
    );

    ex_muldiv_unit #(.XLEN(16), .TAG_W(5)) dut16 (
        .clk(clk), .reset(reset), .start_i(start16), .funct3_i(f3_16),
        .rs1_i(a16), .rs2_i(b16), .rd_i(rd16), .flush_i(flush16),
        .busy_o(busy16), .stall_o(stall16), .done_o(done16),
        .result_o(res16), .rd_o(rd16_o)
    );

    // Scoreboard monitor: every done_o must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && done_o) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got result=%h rd=%0d required no done", result_o, rd_o);
            end else begin
                mon_e = sb.pop_front();
                checks += 3;
                if (result_o !== mon_e.res) begin
                    errors++;
                    $display("FAIL result got %h required %h", result_o, mon_e.res);
                end
                if (rd_o !== mon_e.rd) begin
                    errors++;
                    $display("FAIL rd got %0d required %0d", rd_o, mon_e.rd);
                end
                if (cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL done_cycle got %0d required %0d", cyc, mon_e.due);
                end
                $display("txn done cyc=%0d result=%h rd=%0d", cyc, result_o, rd_o);
            end
        end
    end

    function automatic logic [31:0] ref32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic               ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
            3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                return $signed(a) / $signed(b);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input int lat, input bit push);
        exp_t t;
        funct3_i = f;
        rs1_i    = a;
        rs2_i    = b;
        rd_i     = rd;
        start_i  = 1'b1;
        if (push) begin
            t.res = exp;
            t.rd  = rd;
            t.due = cyc + lat;
            sb.push_back(t);
        end
        $display("txn issue cyc=%0d f3=%0d a=%h b=%h rd=%0d", cyc, f, a, b, rd);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && sb.size() != 0; k++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending %0d required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        checks += 5;
        if (busy_o !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b required 0", busy_o); end
        if (done_o !== 1'b0)     begin errors++; $display("FAIL reset_done got %b required 0", done_o); end
        if (result_o !== 32'h0)  begin errors++; $display("FAIL reset_result got %h required 0", result_o); end
        if (rd_o !== 5'h0)       begin errors++; $display("FAIL reset_rd got %0d required 0", rd_o); end
        if (stall_o !== 1'b0)    begin errors++; $display("FAIL reset_stall got %b required 0", stall_o); end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_mul_edge();
        issue(3'd0, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h0000_0000, 34, 1'b1); drain(60);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000, 34, 1'b1); drain(60);
        issue(3'd3, 32'h8000_0000, 32'h8000_0000, 5'd3, 32'h4000_0000, 34, 1'b1); drain(60);
    endtask

    task automatic test_signed();
        issue(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd4, 32'hFFFF_FFFF, 34, 1'b1); drain(60);
        issue(3'd4, 32'd7, 32'hFFFF_FFFE, 5'd5, 32'hFFFF_FFFD, 34, 1'b1); drain(60);
        issue(3'd6, 32'd7, 32'hFFFF_FFFE, 5'd6, 32'h0000_0001, 34, 1'b1); drain(60);
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 34, 1'b1); drain(60);
    endtask

    task automatic test_special();
        issue(3'd5, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1, 1'b1); drain(10);
        issue(3'd7, 32'd5, 32'd0, 5'd9, 32'h0000_0005, 1, 1'b1); drain(10);
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1, 1'b1); drain(10);
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000, 1, 1'b1); drain(10);
    endtask

    task automatic test_back_to_back();
        int   n0;
        exp_t t;
        n0 = cyc;
        funct3_i = 3'd0; rs1_i = 32'd3; rs2_i = 32'd5; rd_i = 5'd12; start_i = 1'b1;
        t.res = 32'h0000_000F; t.rd = 5'd12; t.due = n0 + 34; sb.push_back(t);
        for (int k = 0; k <= 68; k++) begin
            @(negedge clk);
            checks++;
            if (stall_o !== 1'(k != 68)) begin
                errors++;
                $display("FAIL b2b_stall cycle N+%0d got %b required %b", k, stall_o, 1'(k != 68));
            end
            @(posedge clk);
            #1;
            if (cyc == n0 + 34) begin
                funct3_i = 3'd5; rs1_i = 32'd100; rs2_i = 32'd7; rd_i = 5'd13; start_i = 1'b1;
                t.res = 32'h0000_000E; t.rd = 5'd13; t.due = n0 + 68; sb.push_back(t);
            end else begin
                start_i = 1'b0;
            end
        end
        drain(5);
    endtask

    task automatic test_flush();
        int n0;
        n0 = cyc;
        issue(3'd4, 32'd1000, 32'd3, 5'd9, 32'h0, 34, 1'b0);
        while (cyc < n0 + 10) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        @(negedge clk);
        checks += 3;
        if (busy_o !== 1'b0)           begin errors++; $display("FAIL flush_busy got %b required 0", busy_o); end
        if (stall_o !== 1'b0)          begin errors++; $display("FAIL flush_stall got %b required 0", stall_o); end
        if (result_o !== 32'h0000_000E) begin errors++; $display("FAIL flush_result got %h required %h", result_o, 32'h0000_000E); end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            checks++;
            if (done_o !== 1'b0) begin errors++; $display("FAIL flush_no_done got %b required 0", done_o); end
        end
        @(posedge clk);
        #1;
        funct3_i = 3'd5; rs1_i = 32'd5; rs2_i = 32'd0; rd_i = 5'd14;
        start_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_o !== 1'b0) begin errors++; $display("FAIL flush_start_stall got %b required 0", stall_o); end
        @(posedge clk);
        #1;
        start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        checks += 2;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL flush_start_accept done=%b busy=%b required 0 0", done_o, busy_o);
        end
        if (result_o !== 32'h0000_000E) begin errors++; $display("FAIL flush_start_result got %h required %h", result_o, 32'h0000_000E); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int n0;
        n0 = cyc;
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd15, 32'h0, 34, 1'b0);
        while (cyc < n0 + 20) begin @(posedge clk); #1; end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks += 4;
        if (busy_o !== 1'b0)    begin errors++; $display("FAIL midreset_busy got %b required 0", busy_o); end
        if (done_o !== 1'b0)    begin errors++; $display("FAIL midreset_done got %b required 0", done_o); end
        if (result_o !== 32'h0) begin errors++; $display("FAIL midreset_result got %h required 0", result_o); end
        if (rd_o !== 5'h0)      begin errors++; $display("FAIL midreset_rd got %0d required 0", rd_o); end
        @(posedge clk);
        #1;
        issue(3'd0, 32'd6, 32'd7, 5'd16, 32'h0000_002A, 34, 1'b1);
        drain(60);
    endtask

    task automatic test_xlen16();
        int          n0;
        int          got_cyc;
        logic [15:0] got_res;
        logic [4:0]  got_rd;
        got_cyc = -1; got_res = '0; got_rd = '0;
        n0 = cyc;
        f3_16 = 3'd0; a16 = 16'd3; b16 = 16'd5; rd16 = 5'd4; start16 = 1'b1;
        @(posedge clk);
        #1;
        start16 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done16 && got_cyc < 0) begin got_cyc = cyc; got_res = res16; got_rd = rd16_o; end
        end
        $display("txn x16 done cyc=%0d result=%h rd=%0d", got_cyc, got_res, got_rd);
        checks += 3;
        if (got_cyc != n0 + 18)  begin errors++; $display("FAIL x16_latency got %0d required %0d", got_cyc, n0 + 18); end
        if (got_res !== 16'h000F) begin errors++; $display("FAIL x16_result got %h required 000f", got_res); end
        if (got_rd !== 5'd4)      begin errors++; $display("FAIL x16_rd got %0d required 4", got_rd); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        for (int i = 0; i < 16; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
            lat = (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
            issue(f, a, b, 5'(i + 17), ref32(f, a, b), lat, 1'b1);
            drain(60);
        end
    endtask

    initial begin
        reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; funct3_i = '0;
        rs1_i = '0; rs2_i = '0; rd_i = '0;
        start16 = 1'b0; flush16 = 1'b0; f3_16 = '0; a16 = '0; b16 = '0; rd16 = '0;
        test_reset();
        test_mul_edge();
        test_signed();
        test_special();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_xlen16();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
